// File: rtl/thread_dispatch_scheduler_pkg.sv
// Shared types for the thread dispatch scheduler and its neighbours
// (context cache ids, returned thread context, scheduler state).
package thread_dispatch_scheduler_pkg;

    localparam int unsigned THREAD_ID_W = 8;

    typedef logic [THREAD_ID_W-1:0] thread_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] stack_ptr;
        logic [7:0]  flags;
    } thread_program_stuct_t;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_RUN,
        SCHED_DRAIN
    } sched_state_t;

    // The cache view lags one cycle behind an in-flight request, so that
    // request is subtracted here; an empty view while in flight cannot
    // occur, but is clamped to zero rather than wrapping.
    function automatic thread_id_t eff_waiting_count(input thread_id_t count,
                                                     input logic       inflight);
        if (!inflight) begin
            return count;
        end else if (count == '0) begin
            return '0;
        end else begin
            return count - thread_id_t'(1);
        end
    endfunction

endpackage

// File: rtl/thread_dispatch_scheduler_dispatch_fifo.sv
// Synchronous FIFO for returned thread contexts. The head entry is read
// straight out of the storage registers, so it holds steady until popped.
module dispatch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (occupancy == '0);
    assign full      = (occupancy == DEPTH_CNT);
    assign do_pop    = pop & ~empty;
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy update (+push -pop).
    always_ff @(posedge clk) begin
        if (rst) begin
            mem       <= '{default: '0};
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/thread_dispatch_scheduler.sv
// Scheduler downstream of the context cache: requests threads from the
// cache's waiting queue, buffers the returned contexts and hands them to
// the execute stage over valid/ready.
module thread_dispatch_scheduler
    import thread_dispatch_scheduler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  thread_id_t            waiting_thread_count,
    input  thread_id_t            waiting_next_id,
    input  thread_id_t            waiting_next_id2,
    output logic                  requesting_thread,
    output thread_id_t            requested_thread_id,
    input  thread_program_stuct_t requested_thread_return,
    input  thread_id_t            out_thread_id,
    output logic                  exec_valid,
    input  logic                  exec_ready,
    output thread_program_stuct_t exec_thread,
    output thread_id_t            exec_thread_id,
    output logic                  sched_idle,
    output logic [CNT_W-1:0]      issue_count
);
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = $bits(thread_program_stuct_t) + $bits(thread_id_t);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    sched_state_t     state;
    sched_state_t     state_next;
    logic             inflight;
    logic             issue;
    logic             has_credit;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] occupancy;
    thread_id_t       eff_count;
    thread_id_t       candidate;
    logic [ENTRY_W-1:0] head_entry;

    assign inflight  = requesting_thread;
    assign eff_count = eff_waiting_count(waiting_thread_count, inflight);
    assign candidate = inflight ? waiting_next_id2 : waiting_next_id;
    // A slot freed by a same-cycle pop is not reused until the next cycle.
    assign has_credit = (occupancy + OCC_W'(inflight)) < DEPTH_OCC;

    assign fifo_pop   = exec_valid & exec_ready;
    assign exec_valid = ~fifo_empty;
    assign {exec_thread, exec_thread_id} = head_entry;
    assign sched_idle = (state == SCHED_IDLE) & ~inflight & fifo_empty;

    dispatch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({requested_thread_return, out_thread_id}),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    // Credit accounting must never let a return land in a full FIFO.
    assert property (@(posedge clk) disable iff (rst) inflight |-> (!fifo_full || fifo_pop));

    // Next-state and issue decision.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            SCHED_IDLE: begin
                if (enable) state_next = SCHED_RUN;
            end
            SCHED_RUN: begin
                if (!enable) state_next = SCHED_DRAIN;
                else         issue = (eff_count != '0) && has_credit;
            end
            SCHED_DRAIN: begin
                if (enable)                         state_next = SCHED_RUN;
                else if (!inflight && fifo_empty)   state_next = SCHED_IDLE;
            end
            default: state_next = SCHED_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= SCHED_IDLE;
        else     state <= state_next;
    end

    // Registered request strobe, requested id and issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            requesting_thread   <= 1'b0;
            requested_thread_id <= '0;
            issue_count         <= '0;
        end else begin
            requesting_thread <= issue;
            if (issue) begin
                requested_thread_id <= candidate;
                issue_count         <= issue_count + 1'b1;
            end
        end
    end

endmodule
